// File: rtl/i2s_rx_if.sv
// i2s_rx_if: I2S serial pins plus the recovered PCM pair and link status
interface i2s_rx_if #(parameter int AUDIO_DW = 16);
    logic                sclk, lrclk, sdata, signed_sample;
    logic [AUDIO_DW-1:0] left_out, right_out;
    logic                sample_valid, locked;
    modport master(output sclk, lrclk, sdata, signed_sample, input left_out, right_out, sample_valid, locked);
    modport slave(input sclk, lrclk, sdata, signed_sample, output left_out, right_out, sample_valid, locked);
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S deserializer with frame lock and sclk watchdog
// Rebuilds stereo PCM pairs from sclk/lrclk/sdata sampled in the clk_sys domain.
module i2s_rx #(
    parameter int AUDIO_DW = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic    clk_sys,
    input  logic    reset,
    i2s_rx_if.slave io_i2s
);
    localparam int CW = $clog2(AUDIO_DW + 2);
    localparam int WW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    typedef enum logic [1:0] {HUNT, SYNC1, SYNC2, LOCK} state_t;
    state_t              r_state, w_state_nx;
    logic [2:0]          r_sclk_s;
    logic [1:0]          r_lr_s, r_sd_s;
    logic                r_lr_prev, r_armed, r_left_ok, r_valid, w_armed_nx, w_locked;
    logic [CW-1:0]       r_cnt;
    logic [WW-1:0]       r_wd;
    logic [AUDIO_DW-1:0] r_shift, r_hold, r_left, r_right, w_mask, w_fill, w_word;
    logic                w_rise, w_bnd, w_ok, w_to, w_pair;
    assign w_rise = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_bnd  = w_rise & (r_lr_s[1] != r_lr_prev);
    assign w_ok   = r_cnt == CW'(AUDIO_DW - 1);
    assign w_to   = ~w_rise & (r_wd >= WW'(TIMEOUT - 1));
    assign w_pair = w_bnd & r_lr_prev & (r_state != HUNT);
    // Each bit lands directly in its left-justified slot; bits beyond AUDIO_DW are dropped.
    assign w_mask = (r_cnt < CW'(AUDIO_DW)) ? (AUDIO_DW'(1) << (CW'(AUDIO_DW - 1) - r_cnt)) : '0;
    assign w_fill = r_sd_s[1] ? (r_shift | w_mask) : r_shift;
    assign w_word = w_fill ^ {~io_i2s.signed_sample, {(AUDIO_DW - 1){1'b0}}};
    always_comb begin
        w_state_nx = r_state;
        w_locked   = r_state == LOCK;
        if (w_to)
            w_state_nx = HUNT;
        else if (w_bnd & r_lr_prev)
            w_state_nx = (r_state == HUNT) ? (r_armed ? SYNC1 : HUNT) :
                         !(r_left_ok & w_ok) ? HUNT : (r_state == SYNC1) ? SYNC2 : LOCK;
        w_armed_nx = (r_state == HUNT) & (w_state_nx == HUNT) & ~w_to & (r_armed | w_bnd);
    end
    always_ff @(posedge clk_sys)
        r_state <= reset ? HUNT : w_state_nx;
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sclk_s  <= '0;
            r_lr_s    <= '0;
            r_sd_s    <= '0;
            r_lr_prev <= 1'b0;
            r_armed   <= 1'b0;
            r_left_ok <= 1'b0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
            r_wd      <= '0;
            r_shift   <= '0;
            r_hold    <= '0;
            r_left    <= '0;
            r_right   <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], io_i2s.sclk};
            r_lr_s   <= {r_lr_s[0], io_i2s.lrclk};
            r_sd_s   <= {r_sd_s[0], io_i2s.sdata};
            r_armed  <= w_armed_nx;
            r_valid  <= w_pair;
            r_wd     <= w_rise ? '0 : w_to ? WW'(TIMEOUT) : r_wd + WW'(1);
            if (w_rise) begin
                r_lr_prev <= r_lr_s[1];
                r_cnt     <= w_bnd ? '0 : (r_cnt == CW'(AUDIO_DW + 1)) ? r_cnt : r_cnt + CW'(1);
                r_shift   <= w_bnd ? '0 : w_fill;
            end
            if (w_bnd & ~r_lr_prev) begin
                r_hold    <= w_word;
                r_left_ok <= w_ok;
            end
            if (w_pair) begin
                r_left  <= r_hold;
                r_right <= w_word;
            end
        end
    end
    assign io_i2s.left_out     = r_left;
    assign io_i2s.right_out    = r_right;
    assign io_i2s.sample_valid = r_valid;
    assign io_i2s.locked       = w_locked;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S frames against a word-level reference model, scoreboard-checked
module tb_i2s_rx;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    always #5 clk_sys = ~clk_sys;
    i2s_rx_if #(.AUDIO_DW(16)) bus();
    i2s_rx #(.AUDIO_DW(16), .TIMEOUT(255)) dut (.clk_sys(clk_sys), .reset(reset), .io_i2s(bus));
    int n_cmp = 0, n_fail = 0, n_valid = 0, half = 8;
    int cyc = 0, rise_cyc = 0, valid_cyc = 0, v0 = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pair = '0;
    int m_st = 0;
    bit m_armed = 0, m_lok = 0;
    logic [15:0] m_hold = '0;
    always @(posedge clk_sys) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(negedge clk_sys)
        if (!reset && bus.sample_valid === 1'b1) begin
            n_valid++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got pair %h expected no strobe", {bus.left_out, bus.right_out});
            end else
                chk("pair", {bus.left_out, bus.right_out}, exp_q.pop_front());
        end
    // Stored word: keep the first 16 received bits MSB-justified, zero-fill short words.
    function automatic logic [15:0] expw(input logic [31:0] v, input int nb, input bit sgn);
        logic [31:0] t = (nb >= 16) ? (v >> (nb - 16)) : (v << (16 - nb));
        return {t[15] ^ ~sgn, t[14:0]};
    endfunction
    task automatic model_word(input bit ch, input logic [15:0] w, input bit ok);
        if (!ch) begin
            m_hold = w;
            m_lok = ok;
            if (m_st == 0) m_armed = 1;
        end else if (m_st == 0) begin
            m_st = m_armed ? 1 : 0;
            m_armed = !m_armed;
        end else begin
            exp_q.push_back({m_hold, w});
            last_pair = {m_hold, w};
            m_st = (m_lok && ok) ? ((m_st == 3) ? 3 : m_st + 1) : 0;
        end
    endtask
    task automatic slot(input bit lr, input bit d);
        bus.sclk = 1'b0;
        bus.lrclk = lr;
        bus.sdata = d;
        repeat (half) @(negedge clk_sys);
        bus.sclk = 1'b1;
        rise_cyc = cyc;
        repeat (half) @(negedge clk_sys);
    endtask
    task automatic send_word(input bit ch, input logic [31:0] v, input int nb, input bit sgn);
        model_word(ch, expw(v, nb, sgn), nb == 16);
        for (int b = nb - 1; b >= 0; b--) slot((b == 0) ? !ch : ch, v[b]);
    endtask
    task automatic send_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv, input int rn, input bit sgn);
        bus.signed_sample = sgn;
        send_word(0, lv, ln, sgn);
        send_word(1, rv, rn, sgn);
        bus.sclk = 1'b0;
        repeat (6) @(negedge clk_sys);
    endtask
    task automatic rnd_frame(input bit sgn);
        send_frame(32'($urandom_range(0, 16'hFFFF)), 16, 32'($urandom_range(0, 16'hFFFF)), 16, sgn);
    endtask
    task automatic chk_lock(input string nm);
        chk(nm, 32'(bus.locked), 32'(m_st == 3));
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_left"}, 32'(bus.left_out), 0);
        chk({nm, "_right"}, 32'(bus.right_out), 0);
        chk({nm, "_valid"}, 32'(bus.sample_valid), 0);
        chk({nm, "_locked"}, 32'(bus.locked), 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        bus.sclk = 1'b0;
        bus.lrclk = 1'b0;
        bus.sdata = 1'b0;
        bus.signed_sample = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        v0 = n_valid;
        for (int f = 0; f < 3; f++) begin
            rnd_frame(1);
            chk_lock($sformatf("lock_frame%0d", f + 1));
        end
        chk("valids_before_lock", 32'(n_valid - v0), 2);
        half = 24;
        v0 = n_valid;
        send_frame(32'h1234, 16, 32'hABCD, 16, 1);
        chk("single_pulse", 32'(n_valid - v0), 1);
        chk("latency", 32'(valid_cyc - rise_cyc), 3);
        half = 8;
        send_frame(32'h8000, 16, 32'h7FFF, 16, 0);
        for (int f = 0; f < 6; f++) rnd_frame(1'($urandom_range(0, 1)));
        chk_lock("still_locked");
        send_frame(32'h12345, 18, 32'hABC, 12, 1);
        chk_lock("malformed_unlock");
        for (int f = 0; f < 3; f++) rnd_frame(1);
        chk_lock("relock_after_malformed");
        while (cyc < rise_cyc + 250) @(negedge clk_sys);
        chk("lock_before_timeout", 32'(bus.locked), 1);
        while (cyc < rise_cyc + 265) @(negedge clk_sys);
        chk("lock_after_timeout", 32'(bus.locked), 0);
        chk("hold_after_timeout", {bus.left_out, bus.right_out}, last_pair);
        m_st = 0;
        m_armed = 0;
        for (int f = 0; f < 3; f++) rnd_frame(1);
        chk_lock("relock_after_timeout");
        bus.signed_sample = 1'b1;
        for (int b = 15; b >= 0; b--) slot(b == 0, 1'($urandom_range(0, 1)));
        for (int b = 0; b < 8; b++) slot(1, 1'($urandom_range(0, 1)));
        bus.sclk = 1'b0;
        bus.lrclk = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk_zero("midreset");
        reset = 1'b0;
        m_st = 0;
        m_armed = 0;
        repeat (5) @(negedge clk_sys);
        v0 = n_valid;
        for (int f = 0; f < 3; f++) begin
            rnd_frame(1);
            chk_lock($sformatf("post_reset_frame%0d", f + 1));
        end
        chk("post_reset_valids", 32'(n_valid - v0), 2);
        repeat (20) @(negedge clk_sys);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
